// File: rtl/repl_victim_ctrl_pkg.sv
// Shared definitions for the miss-handling victim controller: state encoding,
// beat-counter sizing and way index/one-hot conversion.
package repl_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    RDVIC  = 3'd2,
    WB     = 3'd3,
    REQ    = 3'd4,
    FILL   = 3'd5,
    COMMIT = 3'd6
  } victim_state_t;

  // Widest supported associativity; narrower configurations slice the low bits.
  localparam int MAX_WAYS  = 4;
  localparam int WAY_IDX_W = 2;

  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic logic [MAX_WAYS-1:0] idx_to_onehot(input logic [WAY_IDX_W-1:0] idx);
    logic [MAX_WAYS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [WAY_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
    logic [WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (oh[i]) idx = i[WAY_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/repl_victim_ctrl_line_assembler.sv
// Refill line builder: places in-order memory beats into the line register
// and flags the final beat of a burst.
module line_assembler
  import repl_defs::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [MEM_WIDTH-1:0]  beat_data,
  output logic                  last,
  output logic [LINE_WIDTH-1:0] line
);

  localparam int BEATS = LINE_WIDTH / MEM_WIDTH;
  localparam int CNT_W = beat_cnt_w(BEATS);

  logic [CNT_W-1:0]      r_cnt;
  logic [LINE_WIDTH-1:0] r_line;

  // The counter wraps to zero after the final beat because BEATS is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (beat_valid) begin
      r_line[r_cnt*MEM_WIDTH +: MEM_WIDTH] <= beat_data;
      r_cnt                                <= r_cnt + 1'b1;
    end
  end

  assign last = beat_valid && (r_cnt == CNT_W'(BEATS - 1));
  assign line = r_line;

endmodule

// File: rtl/repl_victim_ctrl.sv
// Cache miss controller: chooses a victim way, writes it back when dirty,
// refills the line from memory and reports the fill to the replacement policy.
module repl_victim_ctrl
  import repl_defs::*;
#(
  parameter int SET_ASSOC  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req,
  input  logic [ADDR_WIDTH-1:0]        miss_addr,
  output logic                         miss_ready,
  input  logic [SET_ASSOC-1:0]         set_valid,
  input  logic [SET_ASSOC-1:0]         set_dirty,
  input  logic [$clog2(SET_ASSOC)-1:0] repl_index,
  output logic [SET_ASSOC-1:0]         victim_way,
  input  logic [ADDR_WIDTH-1:0]        victim_tag_addr,
  input  logic [LINE_WIDTH-1:0]        victim_data,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_WIDTH-1:0]        wb_addr,
  output logic [LINE_WIDTH-1:0]        wb_data,
  output logic                         mem_req,
  input  logic                         mem_gnt,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_rvalid,
  input  logic [MEM_WIDTH-1:0]         mem_rdata,
  output logic                         fill_we,
  output logic [LINE_WIDTH-1:0]        fill_data,
  output logic [SET_ASSOC-1:0]         access,
  output logic                         update
);

  localparam int IDX_W = $clog2(SET_ASSOC);

  victim_state_t r_state;
  victim_state_t w_next;

  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [SET_ASSOC-1:0]  r_victim_way;
  logic                  r_victim_dv;
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [LINE_WIDTH-1:0] r_wb_data;

  logic [IDX_W-1:0]     w_sel_idx;
  logic [WAY_IDX_W-1:0] w_sel_idx_ext;
  logic [MAX_WAYS-1:0]  w_sel_oh_full;
  logic [SET_ASSOC-1:0] w_sel_oh;
  logic                 w_sel_dv;
  logic                 w_clear;
  logic                 w_beat_valid;
  logic                 w_last;

  // Free ways win over the policy; the descending scan leaves the lowest free way.
  always_comb begin
    w_sel_idx = repl_index;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!set_valid[i]) w_sel_idx = i[IDX_W-1:0];
    end
  end

  assign w_sel_idx_ext = WAY_IDX_W'(w_sel_idx);
  assign w_sel_oh_full = idx_to_onehot(w_sel_idx_ext);
  assign w_sel_oh      = w_sel_oh_full[SET_ASSOC-1:0];
  assign w_sel_dv      = set_dirty[w_sel_idx] & set_valid[w_sel_idx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      IDLE:    if (miss_req) w_next = SELECT;
      SELECT:  w_next = RDVIC;
      RDVIC:   w_next = r_victim_dv ? WB : REQ;
      WB:      if (wb_ready) w_next = REQ;
      REQ: begin
        if (mem_gnt) begin
          w_next  = FILL;
          w_clear = 1'b1;
        end
      end
      FILL:    if (w_last) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_addr  <= '0;
      r_victim_way <= '0;
      r_victim_dv  <= 1'b0;
      r_wb_addr    <= '0;
    end else begin
      if (r_state == IDLE && miss_req) r_miss_addr <= miss_addr;
      if (r_state == SELECT) begin
        r_victim_way <= w_sel_oh;
        r_victim_dv  <= w_sel_dv;
      end else if (r_state == COMMIT) begin
        r_victim_way <= '0;
      end
      if (r_state == RDVIC) r_wb_addr <= victim_tag_addr;
    end
  end

  // Victim line arrives one cycle after SELECT and is held for the writeback.
  always_ff @(posedge clk) begin
    if (r_state == RDVIC) r_wb_data <= victim_data;
  end

  assign w_beat_valid = (r_state == FILL) && mem_rvalid;

  line_assembler #(
    .LINE_WIDTH (LINE_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_line_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_clear),
    .beat_valid (w_beat_valid),
    .beat_data  (mem_rdata),
    .last       (w_last),
    .line       (fill_data)
  );

  assign miss_ready = (r_state == IDLE);
  assign wb_valid   = (r_state == WB);
  assign mem_req    = (r_state == REQ);
  assign fill_we    = (r_state == COMMIT);
  assign update     = (r_state == COMMIT);
  assign access     = (r_state == COMMIT) ? r_victim_way : '0;
  assign victim_way = r_victim_way;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign mem_addr   = r_miss_addr;

endmodule

// File: tb/tb_repl_victim_ctrl.sv
// Scoreboard bench for repl_victim_ctrl: a driver issues misses and services
// the writeback/memory handshakes, a monitor checks every DUT transaction.
module tb_repl_victim_ctrl;

  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic [3:0]   set_valid = '0;
  logic [3:0]   set_dirty = '0;
  logic [1:0]   repl_index = '0;
  logic [3:0]   victim_way;
  logic [31:0]  victim_tag_addr = '0;
  logic [255:0] victim_data = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic         mem_req;
  logic         mem_gnt = 1'b0;
  logic [31:0]  mem_addr;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         fill_we;
  logic [255:0] fill_data;
  logic [3:0]   access;
  logic         update;

  repl_victim_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .miss_req        (miss_req),
    .miss_addr       (miss_addr),
    .miss_ready      (miss_ready),
    .set_valid       (set_valid),
    .set_dirty       (set_dirty),
    .repl_index      (repl_index),
    .victim_way      (victim_way),
    .victim_tag_addr (victim_tag_addr),
    .victim_data     (victim_data),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .mem_req         (mem_req),
    .mem_gnt         (mem_gnt),
    .mem_addr        (mem_addr),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .fill_we         (fill_we),
    .fill_data       (fill_data),
    .access          (access),
    .update          (update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]  q_wb_addr[$];
  logic [255:0] q_wb_data[$];
  logic [31:0]  q_mem[$];
  logic [255:0] q_line[$];
  logic [3:0]   q_way[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick_way(input logic [3:0] v, input logic [1:0] ridx);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return int'(ridx);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pop the expected transaction whenever the DUT presents one.
  logic [31:0]  m_addr;
  logic [255:0] m_data;
  logic [3:0]   m_way;
  logic         prev_we = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid && wb_ready) begin
        if (q_wb_addr.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wb_unexpected: got addr %h with no writeback expected", wb_addr);
        end else begin
          m_addr = q_wb_addr.pop_front();
          m_data = q_wb_data.pop_front();
          chk("wb_addr", 256'(wb_addr), 256'(m_addr));
          chk("wb_data", wb_data, m_data);
        end
      end
      if (mem_req && mem_gnt) begin
        if (q_mem.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexpected: got addr %h with no refill expected", mem_addr);
        end else begin
          m_addr = q_mem.pop_front();
          chk("mem_addr", 256'(mem_addr), 256'(m_addr));
        end
      end
      if (fill_we) begin
        if (q_line.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL commit_unexpected: got fill_we=1 with no commit expected");
        end else begin
          m_data = q_line.pop_front();
          m_way  = q_way.pop_front();
          chk("fill_data", fill_data, m_data);
          chk("access", 256'(access), 256'(m_way));
          chk("victim_way", 256'(victim_way), 256'(m_way));
        end
      end
      if (fill_we || update) chk("update_with_fill_we", 256'(update), 256'(fill_we));
      if (prev_we) chk("fill_we_one_cycle", 256'(fill_we), 256'(0));
      prev_we = fill_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // gap_mode: 0 = beat every FILL cycle, 1 = beat on every second cycle, 2 = random with noise outside FILL
  task automatic do_miss(input logic [31:0] addr, input logic [3:0] v, input logic [3:0] d,
                         input logic [1:0] ridx, input logic [31:0] vtag, input int wb_delay,
                         input int gnt_delay, input int gap_mode, input bit hold,
                         input int abort_beat, input bit seq_data,
                         output int e_a, output int e_c);
    int vic, wbc, gc, f, nb;
    bit dirty, acc, saw_ready, in_fill, done, aborting, go, wb_done;
    logic [31:0]  beats[BEATS];
    logic [255:0] line, vdata;
    vic   = pick_way(v, ridx);
    dirty = d[vic] & v[vic];
    vdata = rand256();
    for (int k = 0; k < BEATS; k++) begin
      beats[k]          = seq_data ? 32'(k) : $urandom;
      line[k*32 +: 32]  = beats[k];
    end
    if (dirty) begin
      q_wb_addr.push_back(vtag);
      q_wb_data.push_back(vdata);
    end
    q_mem.push_back(addr);
    if (abort_beat < 0) begin
      q_line.push_back(line);
      q_way.push_back(4'(1 << vic));
    end
    miss_addr = addr; set_valid = v; set_dirty = d; repl_index = ridx;
    victim_tag_addr = vtag; victim_data = vdata; miss_req = 1'b1;
    saw_ready = miss_ready;
    acc = 0; in_fill = 0; done = 0; aborting = 0; wb_done = 0;
    wbc = 0; gc = 0; f = 0; nb = 0; e_a = 0; e_c = 0;
    for (int it = 0; it < 400 && !done; it++) begin
      @(posedge clk); #1;
      if (aborting) begin
        chk("abort_miss_ready", 256'(miss_ready), 256'(1));
        chk("abort_strobes", 256'({wb_valid, mem_req, fill_we, update}), 256'(0));
        chk("abort_victim_way", 256'(victim_way), 256'(0));
        rst = 1'b0;
        done = 1;
      end else begin
        rst = 1'b0;
        if (!acc) begin
          if (saw_ready && !miss_ready) begin
            acc = 1;
            e_a = cyc;
            if (!hold) miss_req = 1'b0;
          end
          saw_ready = miss_ready;
        end
        if (wb_valid) begin
          wbc++;
          chk("wb_addr_stable", 256'(wb_addr), 256'(vtag));
          chk("wb_data_stable", wb_data, vdata);
          wb_ready = (wbc > wb_delay);
          if (wb_ready) wb_done = 1;
        end else begin
          wb_ready = 1'b0;
        end
        if (acc && dirty && !wb_done) chk("no_req_before_wb", 256'(mem_req), 256'(0));
        if (mem_req) begin
          gc++;
          mem_gnt = (gc > gnt_delay);
        end else begin
          mem_gnt = 1'b0;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (in_fill) begin
          f++;
          if (abort_beat >= 0 && nb == abort_beat) begin
            rst = 1'b1;
            aborting = 1;
            miss_req = 1'b0;
          end else begin
            go = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (f % 2 == 0) : 1'($urandom_range(0, 1));
            if (go) begin
              mem_rvalid = 1'b1;
              mem_rdata  = beats[nb];
              nb++;
              if (nb == BEATS) in_fill = 0;
            end
          end
        end else if (gap_mode == 2 && acc) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
        if (mem_gnt) in_fill = 1;
        if (fill_we) begin
          done = 1;
          e_c  = cyc;
          chki("commit_latency", e_c - e_a, 2 + (dirty ? wbc : 0) + gc + f);
        end
      end
    end
    wb_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL miss_timeout: no commit for addr %h within 400 cycles", addr);
      rst = 1'b1; miss_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      q_wb_addr.delete(); q_wb_data.delete(); q_mem.delete(); q_line.delete(); q_way.delete();
    end else if (dirty && abort_beat < 0) begin
      chki("wb_cycles", wbc, wb_delay + 1);
    end
  endtask

  int ea1, ec1, ea2, ec2;

  initial begin
    // Reset held with a pending miss
    rst = 1'b1; miss_req = 1'b1; miss_addr = 32'hdead_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_miss_ready", 256'(miss_ready), 256'(1));
      chk("rst_strobes", 256'({wb_valid, mem_req, fill_we, update}), 256'(0));
      chk("rst_way_access", 256'({victim_way, access}), 256'(0));
      chk("rst_fill_data", fill_data, 256'(0));
      chk("rst_addrs", 256'({wb_addr, mem_addr}), 256'(0));
    end
    miss_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss into the free way 2, zero-wait memory
    do_miss(32'h1000_0040, 4'b1011, 4'b1111, 2'd0, 32'h3000_0000, 0, 0, 0, 0, -1, 1, ea1, ec1);
    chki("clean_latency", ec1 - ea1, BEATS + 3);
    @(posedge clk); #1;
    chk("ready_after_commit", 256'(miss_ready), 256'(1));

    // Dirty policy victim with a slow writeback acceptor
    do_miss(32'h1000_0080, 4'b1111, 4'b1000, 2'd3, 32'h2000_0000, 3, 0, 0, 0, -1, 0, ea1, ec1);
    chki("dirty_latency", ec1 - ea1, BEATS + 3 + 1 + 3);

    // Refill beats on every other cycle
    do_miss(32'h1000_00c0, 4'b0111, 4'b0000, 2'd1, 32'h0, 0, 0, 1, 0, -1, 0, ea1, ec1);
    chki("gapped_latency", ec1 - ea1, 3 + 2 * BEATS);

    // Reset mid-FILL after three beats, then a fresh miss
    do_miss(32'h1000_0100, 4'b1110, 4'b0000, 2'd2, 32'h0, 0, 1, 0, 0, 3, 0, ea1, ec1);
    @(posedge clk); #1;
    chk("post_abort_idle", 256'(miss_ready), 256'(1));
    do_miss(32'h1000_0140, 4'b1101, 4'b0010, 2'd0, 32'h0, 0, 0, 0, 0, -1, 0, ea1, ec1);

    // Back-to-back misses with miss_req held
    do_miss(32'h1000_0180, 4'b1111, 4'b0001, 2'd0, 32'h4000_0000, 0, 0, 0, 1, -1, 0, ea1, ec1);
    do_miss(32'h1000_01c0, 4'b1111, 4'b0000, 2'd1, 32'h0, 0, 0, 0, 0, -1, 0, ea2, ec2);
    chki("b2b_accept_gap", ea2 - ec1, 2);
    chki("b2b_update_sep_ok", int'((ec2 - ec1) >= BEATS + 4), 1);

    // Randomized misses
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_miss($urandom & 32'hffff_ffe0, 4'($urandom), 4'($urandom), 2'($urandom),
              $urandom & 32'hffff_ffe0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              2, 0, -1, 0, ea1, ec1);
    end

    repeat (4) @(posedge clk);
    #1;
    chki("scoreboard_drained", q_wb_addr.size() + q_mem.size() + q_line.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/repl_victim_ctrl.md
# repl_victim_ctrl

Miss-handling controller that consumes the replacement policy's victim index and closes the loop back to it. On a cache miss it picks a victim way, writes back a dirty victim, and refills the line from memory in bursts. It then writes the line into the data/tag arrays and pulses `access`/`update` toward the pseudo-LRU generator. It sits between the cache pipeline (miss handshake, set metadata) and the memory bus.

## Interface
- `SET_ASSOC`, 4: ways per set; only 2 or 4 are supported.
- `ADDR_WIDTH`, 32: byte address width.
- `LINE_WIDTH`, 256: line size in bits.
- `MEM_WIDTH`, 32: memory beat width. `BEATS = LINE_WIDTH/MEM_WIDTH` must be a power of two and ≥2.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `miss_req`  in  1  miss pending
- `miss_addr`  in  ADDR_WIDTH  line-aligned miss address
- `miss_ready`  out  1  controller idle, accepts a miss
- `set_valid`  in  SET_ASSOC  valid bits of the missed set
- `set_dirty`  in  SET_ASSOC  dirty bits of the missed set
- `repl_index`  in  $clog2(SET_ASSOC)  policy's victim way
- `victim_way`  out  SET_ASSOC  one-hot selected way, held from SELECT to COMMIT
- `victim_tag_addr`  in  ADDR_WIDTH  line address of victim; valid 1 cycle after SELECT
- `victim_data`  in  LINE_WIDTH  victim line; valid 1 cycle after SELECT
- `wb_valid` / `wb_ready`  out/in  1  writeback handshake
- `wb_addr`, `wb_data`  out  ADDR_WIDTH, LINE_WIDTH  writeback payload
- `mem_req` / `mem_gnt`  out/in  1  refill request handshake
- `mem_addr`  out  ADDR_WIDTH  refill line address
- `mem_rvalid`, `mem_rdata`  in  1, MEM_WIDTH  refill beats, in order
- `fill_we`  out  1  one-cycle write of `fill_data` and tag into `victim_way`
- `fill_data`  out  LINE_WIDTH  assembled line
- `access`  out  SET_ASSOC  one-hot way to mark most-recently-used
- `update`  out  1  one-cycle policy update strobe

## Operation
- States: IDLE → SELECT → RDVIC → (WB if the victim is dirty and valid) → REQ → FILL → COMMIT → IDLE.
- IDLE:
  - `miss_ready = 1`.
  - On `miss_req & miss_ready`, register `miss_addr` and go to SELECT.
- SELECT:
  - Victim is the lowest-index way with `set_valid = 0`. If all ways are valid, the victim is `repl_index`.
  - Register the victim one-hot into `victim_way`, together with its dirty&valid bit.
- RDVIC:
  - Capture `victim_tag_addr` and `victim_data`.
  - Go to WB if the captured dirty&valid bit is set, else to REQ.
- WB:
  - `wb_valid` held high with stable payload until `wb_ready`.
  - The accepting cycle moves to REQ.
- REQ:
  - `mem_req` held high with `mem_addr` = registered miss address until `mem_gnt`.
  - The grant cycle moves to FILL and clears the beat counter.
- FILL:
  - Each `mem_rvalid` writes `mem_rdata` into `fill_data[cnt*MEM_WIDTH +: MEM_WIDTH]` and increments `cnt`.
  - The counter is `$clog2(BEATS)` bits and is authoritative; the beat with `cnt == BEATS-1` moves to COMMIT.
  - Cycles without `mem_rvalid` stall the FILL state.
- COMMIT:
  - `fill_we = 1`, `update = 1`, `access = victim_way`, all for exactly one cycle.
  - Then return to IDLE.
- `rvalid` outside FILL is ignored. `miss_req` while not idle is not accepted.
- A mid-operation reset returns to IDLE and drops all strobes. It produces no `fill_we` and no `update`.

## Timing
- Reset values:
  - `miss_ready = 1`.
  - `victim_way`, `access`, `fill_data` = 0.
  - `wb_valid`, `mem_req`, `fill_we`, `update` = 0.
  - `wb_addr`, `mem_addr` = 0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Clean miss, zero-wait memory (`mem_gnt` and `mem_rvalid` asserted immediately): accept at T, SELECT at T+1, RDVIC at T+2, REQ at T+3 (grant), FILL from T+4 to T+3+BEATS, COMMIT at T+4+BEATS, `miss_ready` again at T+5+BEATS.
- A dirty miss adds one cycle plus the `wb_ready` wait.
- `update` never coincides with `fill_we` of a different way. The cache ORs `access` from hits with this block's `access`; on a hit/COMMIT collision, COMMIT has priority.

## Structure
- `repl_defs` package holds:
  - the `victim_state_t` enum (IDLE, SELECT, RDVIC, WB, REQ, FILL, COMMIT);
  - the beat-count width helper;
  - the one-hot/index conversion function.
- One natural sub-module, `line_assembler`: the beat counter plus the line register. It exposes `clear`, `beat_valid`, `beat_data`, `last`, and `line`.
- The replacement policy stays external; this block only consumes `repl_index` and drives `access`/`update`.

## Test plan
- Reset with `miss_req = 1`:
  - `miss_ready = 1`;
  - all strobes 0;
  - no acceptance while `rst` is high.
- `set_valid = 4'b1011`, `repl_index = 0`, miss at `0x1000_0040`:
  - `victim_way = 4'b0100`;
  - no WB;
  - `mem_addr = 0x1000_0040`;
  - 8 beats `0x0..0x7` → `fill_data` word k = k;
  - `access = 4'b0100`, `update` for one cycle.
- All ways valid, `repl_index = 3`, `set_dirty[3] = 1`, `victim_tag_addr = 0x2000_0000`, `wb_ready` delayed 3 cycles:
  - `wb_valid` stays high for 4 cycles with a stable payload;
  - `mem_req` only after acceptance.
- `mem_rvalid` gapped every other cycle:
  - FILL lasts 16 cycles;
  - COMMIT occurs exactly once, after the 8th beat.
- Reset asserted mid-FILL at beat 3:
  - next cycle is IDLE;
  - no `fill_we`/`update`;
  - a fresh miss completes normally.
- Back-to-back misses with `miss_req` held high:
  - the second is accepted one cycle after COMMIT;
  - `update` pulses are separated by at least `BEATS+4` cycles.
